aes_key_expander: RTL and testbench

Sequential AES-128 key schedule that sits directly upstream of the Round1 / round datapath stages. It takes the 128-bit master key and emits round keys 0..10 (subkey0 = master key, then subkey1..subkey10), one per accepted handshake beat. It generates one key per beat rather than precomputing all eleven, so downstream round logic can consume keys at its own pace.

---
 rtl/aes_key_expander_if.sv | 13 +
 rtl/aes_key_expander.sv | 92 +++++++++
 tb/tb_aes_key_expander.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_expander_if.sv
// aes_key_expander_if: start/masterkey request side and round-key handshake of the AES-128 key schedule.
interface aes_key_expander_if #(parameter int KEY_W = 128);
    logic             start;
    logic [KEY_W-1:0] masterkey;
    logic             key_ready;
    logic [KEY_W-1:0] round_key;
    logic [3:0]       round_idx;
    logic             key_valid;
    logic             busy;
    logic             done;
    modport master (output start, masterkey, key_ready, input round_key, round_idx, key_valid, busy, done);
    modport slave  (input start, masterkey, key_ready, output round_key, round_idx, key_valid, busy, done);
endinterface

// File: rtl/aes_key_expander.sv
// aes_key_expander: AES-128 key schedule emitting round keys 0..10, one per accepted valid/ready beat.
module aes_key_expander #(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_W      = 128
) (
    input logic              clk,
    input logic              reset,
    aes_key_expander_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, EMIT = 2'd1, DONE = 2'd2;
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    logic [1:0]       state_q, state_d;
    logic [KEY_W-1:0] round_key_q, round_key_d;
    logic [3:0]       round_idx_q, round_idx_d;
    logic             key_valid_q, key_valid_d, busy_q, busy_d, done_q, done_d;
    logic [7:0]       rcon_q, rcon_d;
    logic [31:0]      w3, t, n0, n1, n2, n3;
    logic             accept;
    always_comb begin
        accept = key_valid_q & bus.key_ready;
        w3 = round_key_q[31:0];
        // RotWord folded into the byte order of the S-box lookups
        t  = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]} ^ {rcon_q, 24'h0};
        n0 = round_key_q[127:96] ^ t;
        n1 = round_key_q[95:64] ^ n0;
        n2 = round_key_q[63:32] ^ n1;
        n3 = w3 ^ n2;
        state_d     = state_q;
        round_key_d = round_key_q;
        round_idx_d = round_idx_q;
        key_valid_d = key_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rcon_d      = rcon_q;
        case (state_q)
            IDLE: if (bus.start) begin
                round_key_d = bus.masterkey;
                round_idx_d = 4'd0;
                key_valid_d = 1'b1;
                busy_d      = 1'b1;
                rcon_d      = 8'h01;
                state_d     = EMIT;
            end
            EMIT: if (accept) begin
                if (round_idx_q == 4'(NUM_ROUNDS)) begin
                    key_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end else begin
                    round_key_d = {n0, n1, n2, n3};
                    round_idx_d = round_idx_q + 4'd1;
                    rcon_d      = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            round_key_q <= '0;
            round_idx_q <= 4'd0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rcon_q      <= 8'h01;
        end else begin
            state_q     <= state_d;
            round_key_q <= round_key_d;
            round_idx_q <= round_idx_d;
            key_valid_q <= key_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rcon_q      <= rcon_d;
        end
    end
    assign bus.round_key = round_key_q;
    assign bus.round_idx = round_idx_q;
    assign bus.key_valid = key_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: scoreboard bench; expected round keys come from a FIPS-197 word-array model
// whose S-box is derived from the GF(2^8) inverse and affine map.
module tb_aes_key_expander;
    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K3 = 128'h1ac76d4f3809db6ea555df8213dc6ae9;
    typedef struct packed { logic [127:0] key; logic [3:0] idx; } exp_t;
    logic clk = 1'b0, reset_n = 1'b0;
    always #5 clk = ~clk;
    aes_key_expander_if bus();
    aes_key_expander dut (.clk(clk), .reset(reset_n), .bus(bus));
    exp_t         exp_q[$];
    int           n_chk = 0, n_pass = 0, acc_cnt = 0, done_cnt = 0;
    logic         final_prev = 1'b0;
    logic [127:0] got [16];
    logic [7:0]   sb [256];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [127:0] rkey(input logic [127:0] k, input int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic do_start(input logic [127:0] k);
        exp_t e;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.masterkey = k;
        for (int r = 0; r <= 10; r++) begin
            e.key = rkey(k, r);
            e.idx = 4'(r);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int d0, i;
        d0 = done_cnt;
        i = 0;
        while (done_cnt == d0 && i < bound) begin @(posedge clk); #1; i++; end
        check("done_seen", 128'(done_cnt - d0), 128'd1);
    endtask

    // Monitor: every accepted beat is popped from the scoreboard and compared
    always @(negedge clk) begin
        exp_t e;
        if (bus.done || final_prev) check("done_after_last", 128'(bus.done), 128'(final_prev));
        final_prev = bus.key_valid && bus.key_ready && bus.round_idx == 4'd10;
        if (bus.key_valid && bus.key_ready) begin
            acc_cnt++;
            got[bus.round_idx] = bus.round_key;
            if (exp_q.size() == 0) check("unexpected_accept", 128'(bus.round_idx), 128'hffff);
            else begin
                e = exp_q.pop_front();
                check("mon_idx", 128'(bus.round_idx), 128'(e.idx));
                check("mon_key", bus.round_key, e.key);
            end
        end
        if (bus.done) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]   inv;
        logic [127:0] kr;
        int           a0, d0, cyc;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int j = 0; j < 254; j++) inv = gmul(inv, 8'(x));
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        bus.start = 1'b0;
        bus.masterkey = '0;
        bus.key_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_key", bus.round_key, 128'h0);
        check("rst_idx", 128'(bus.round_idx), 128'h0);
        check("rst_valid", 128'(bus.key_valid), 128'h0);
        check("rst_busy", 128'(bus.busy), 128'h0);
        check("rst_done", 128'(bus.done), 128'h0);
        reset_n = 1'b1;
        // Known-answer vector, unstalled: one key per cycle then done
        bus.key_ready = 1'b1;
        do_start(K1);
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            check("t1_valid", 128'(bus.key_valid), 128'h1);
            check("t1_idx", 128'(bus.round_idx), 128'(i));
        end
        @(negedge clk);
        check("t1_done", 128'(bus.done), 128'h1);
        check("t1_busy", 128'(bus.busy), 128'h0);
        check("t1_k0", got[0], K1);
        check("t1_k1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("t1_k10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        do_start(K2);
        wait_done(40);
        check("t2_k1", got[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        check("t2_k10", got[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        // Backpressure at idx3, then an ignored start mid-expansion
        bus.key_ready = 1'b0;
        do_start(K1);
        bus.key_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.key_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 128'(bus.key_valid), 128'h1);
            check("bp_idx", 128'(bus.round_idx), 128'h3);
            check("bp_key", bus.round_key, rkey(K1, 3));
        end
        @(posedge clk); #1 bus.key_ready = 1'b1;
        @(negedge clk);
        check("bp_hold_idx", 128'(bus.round_idx), 128'h3);
        @(negedge clk);
        check("bp_next_idx", 128'(bus.round_idx), 128'h4);
        check("bp_next_key", bus.round_key, rkey(K1, 4));
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.masterkey = K3;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_done(40);
        check("ign_k10", got[10], rkey(K1, 10));
        do_start(K3);
        wait_done(40);
        check("new_k0", got[0], K3);
        // Asynchronous reset at idx6
        kr = {$urandom, $urandom, $urandom, $urandom};
        bus.key_ready = 1'b0;
        do_start(kr);
        bus.key_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 bus.key_ready = 1'b0;
        check("pre_rst_idx", 128'(bus.round_idx), 128'h6);
        check("pre_rst_key", bus.round_key, rkey(kr, 6));
        #2 reset_n = 1'b0;
        #1;
        check("arst_key", bus.round_key, 128'h0);
        check("arst_idx", 128'(bus.round_idx), 128'h0);
        check("arst_valid", 128'(bus.key_valid), 128'h0);
        check("arst_busy", 128'(bus.busy), 128'h0);
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus.key_ready = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("post_rst_valid", 128'(bus.key_valid), 128'h0);
        end
        // Random keys with random consumer stalls
        for (int n = 0; n < 3; n++) begin
            kr = {$urandom, $urandom, $urandom, $urandom};
            a0 = acc_cnt;
            d0 = done_cnt;
            bus.key_ready = 1'($urandom_range(0, 1));
            do_start(kr);
            cyc = 0;
            while (done_cnt == d0 && cyc < 400) begin
                @(posedge clk); #1;
                bus.key_ready = 1'($urandom_range(0, 1));
                cyc++;
            end
            check("rnd_accepts", 128'(acc_cnt - a0), 128'd11);
            check("rnd_dones", 128'(done_cnt - d0), 128'd1);
        end
        repeat (3) @(posedge clk);
        check("queue_empty", 128'(exp_q.size()), 128'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
